// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps one read outstanding to instruction
// memory and presents the returned word to the decoder through the instruction register.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_rvalid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        fault
);

  typedef enum logic [2:0] {
    START,
    FETCH,
    HOLD,
    DRAIN,
    FAULT
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] pending_pc_q;
  logic [31:0] instr_q;
  logic [31:0] instr_pc_q;

  logic redirect_ok;
  logic redirect_bad;

  assign redirect_ok  = redirect && (redirect_pc[1:0] == 2'b00);
  assign redirect_bad = redirect && (redirect_pc[1:0] != 2'b00);

  // Outputs decode registered state only, so no input reaches an output combinationally.
  assign imem_req    = (state_q == FETCH);
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == HOLD);
  assign fault       = (state_q == FAULT);
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;

  // NOTE: every register here is state, so all updates use non-blocking assignments;
  // a blocking write would let later branches in this block see the new value.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= START;
      pc_q         <= RESET_PC;
      pending_pc_q <= RESET_PC;
      instr_q      <= NOP_INSTR;
      instr_pc_q   <= RESET_PC;
    end else if (state_q != FAULT && redirect_bad) begin
      state_q <= FAULT;
      instr_q <= NOP_INSTR;
    end else begin
      unique case (state_q)
        START: begin
          if (redirect_ok) pc_q <= redirect_pc;
          state_q <= FETCH;
        end

        FETCH: begin
          if (redirect_ok) begin
            // With data in hand the old request is finished and a new one can start at once;
            // otherwise the stale response must be swallowed before re-issuing.
            if (imem_rvalid) begin
              pc_q <= redirect_pc;
            end else begin
              pending_pc_q <= redirect_pc;
              state_q      <= DRAIN;
            end
          end else if (imem_rvalid) begin
            instr_q    <= imem_rdata;
            instr_pc_q <= pc_q;
            state_q    <= HOLD;
          end
        end

        HOLD: begin
          if (redirect_ok) begin
            instr_q <= NOP_INSTR;
            pc_q    <= redirect_pc;
            state_q <= FETCH;
          end else if (instr_ready) begin
            pc_q    <= pc_q + 32'd4;
            state_q <= FETCH;
          end
        end

        DRAIN: begin
          if (redirect_ok) begin
            if (imem_rvalid) begin
              pc_q    <= redirect_pc;
              state_q <= FETCH;
            end else begin
              pending_pc_q <= redirect_pc;
            end
          end else if (imem_rvalid) begin
            pc_q    <= pending_pc_q;
            state_q <= FETCH;
          end
        end

        FAULT: state_q <= FAULT;

        default: state_q <= START;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, backpressure, redirects,
// misaligned-redirect fault and PC wrap, each against hand-computed values.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_rvalid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        fault;

  int checks   = 0;
  int failures = 0;

  fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(NOP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_rvalid(imem_rvalid),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .fault      (fault)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance one cycle; outputs are then sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starting in the first FETCH cycle at addr, wait lat cycles, return data, land in HOLD.
  task automatic fetch_resp(input logic [31:0] addr, input logic [31:0] data, input int lat);
    for (int i = 0; i < lat; i++) begin
      check("req_wait", {31'd0, imem_req}, 32'd1);
      check("addr_wait", imem_addr, addr);
      tick();
    end
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    check("req_resp", {31'd0, imem_req}, 32'd1);
    check("addr_resp", imem_addr, addr);
    tick();
    imem_rvalid = 1'b0;
    imem_rdata  = 32'd0;
    check("hold_valid", {31'd0, instr_valid}, 32'd1);
    check("hold_instr", instr, data);
    check("hold_pc", instr_pc, addr);
  endtask

  initial begin
    reset       = 1'b1;
    imem_rdata  = 32'd0;
    imem_rvalid = 1'b0;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'd0;

    // Reset state
    tick();
    tick();
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_fault", {31'd0, fault}, 32'd0);
    check("rst_instr", instr, NOP);
    check("rst_instr_pc", instr_pc, 32'd0);
    reset = 1'b0;
    check("start_req", {31'd0, imem_req}, 32'd0);
    tick();

    // Sequential fetch, L=2, decode always ready
    instr_ready = 1'b1;
    fetch_resp(32'h0, 32'h0050_0093, 2);
    tick();
    check("seq_valid_drop0", {31'd0, instr_valid}, 32'd0);
    fetch_resp(32'h4, 32'h00A0_0113, 2);
    tick();
    check("seq_valid_drop1", {31'd0, instr_valid}, 32'd0);
    check("seq_next_addr", imem_addr, 32'h8);

    // Backpressure for 5 cycles in HOLD
    instr_ready = 1'b0;
    fetch_resp(32'h8, 32'h1234_5678, 1);
    for (int i = 0; i < 5; i++) begin
      check("bp_instr", instr, 32'h1234_5678);
      check("bp_pc", instr_pc, 32'h8);
      check("bp_req", {31'd0, imem_req}, 32'd0);
      check("bp_valid", {31'd0, instr_valid}, 32'd1);
      tick();
    end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    check("bp_release_req", {31'd0, imem_req}, 32'd1);
    check("bp_release_addr", imem_addr, 32'hC);

    // Redirect mid-fetch, L=4: stale response must be drained, latest target wins
    tick();
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    tick();
    check("drain_req0", {31'd0, imem_req}, 32'd0);
    redirect_pc = 32'h200;
    tick();
    redirect = 1'b0;
    check("drain_req1", {31'd0, imem_req}, 32'd0);
    tick();
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    check("drain_req2", {31'd0, imem_req}, 32'd0);
    check("drain_valid", {31'd0, instr_valid}, 32'd0);
    tick();
    imem_rvalid = 1'b0;
    imem_rdata  = 32'd0;
    check("drain_new_req", {31'd0, imem_req}, 32'd1);
    check("drain_new_addr", imem_addr, 32'h200);
    check("drain_no_stale", instr, 32'h1234_5678);
    check("drain_valid_after", {31'd0, instr_valid}, 32'd0);
    fetch_resp(32'h200, 32'h02A0_0193, 1);

    // Redirect and handshake together in HOLD: redirect wins, instr flushed
    redirect    = 1'b1;
    redirect_pc = 32'h40;
    instr_ready = 1'b1;
    tick();
    redirect    = 1'b0;
    instr_ready = 1'b0;
    check("rh_req", {31'd0, imem_req}, 32'd1);
    check("rh_addr", imem_addr, 32'h40);
    check("rh_instr", instr, NOP);
    check("rh_valid", {31'd0, instr_valid}, 32'd0);

    // Redirect coinciding with rvalid in FETCH, then PC wrap
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0BAD_F00D;
    tick();
    redirect    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'd0;
    check("rv_req", {31'd0, imem_req}, 32'd1);
    check("rv_addr", imem_addr, 32'hFFFF_FFFC);
    check("rv_instr", instr, NOP);
    check("rv_valid", {31'd0, instr_valid}, 32'd0);
    fetch_resp(32'hFFFF_FFFC, 32'h0000_0033, 1);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    check("wrap_req", {31'd0, imem_req}, 32'd1);
    check("wrap_addr", imem_addr, 32'h0);

    // Misaligned redirect: sticky fault until reset
    redirect    = 1'b1;
    redirect_pc = 32'h102;
    tick();
    check("flt_fault", {31'd0, fault}, 32'd1);
    check("flt_req", {31'd0, imem_req}, 32'd0);
    check("flt_valid", {31'd0, instr_valid}, 32'd0);
    check("flt_instr", instr, NOP);
    redirect_pc = 32'h80;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h1111_2222;
    instr_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("flt_sticky", {31'd0, fault}, 32'd1);
      check("flt_sticky_req", {31'd0, imem_req}, 32'd0);
      check("flt_sticky_valid", {31'd0, instr_valid}, 32'd0);
      check("flt_sticky_instr", instr, NOP);
    end
    redirect    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'd0;
    instr_ready = 1'b0;
    reset       = 1'b1;
    tick();
    reset = 1'b0;
    check("rerst_fault", {31'd0, fault}, 32'd0);
    check("rerst_req", {31'd0, imem_req}, 32'd0);
    check("rerst_instr_pc", instr_pc, 32'd0);
    tick();
    check("rerst_fetch_req", {31'd0, imem_req}, 32'd1);
    check("rerst_fetch_addr", imem_addr, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
